modulo_contador_rolhas: RTL and testbench
=========================================

Name: modulo_contador_rolhas

Overview:
Cork-stock counter for the bottle-sealing station. It holds the number of corks in the sealing head (0..99) and consumes one cork per sealing request from the bottle sensor. It refills the head from the external dispenser, one cork per cycle in fixed batches, whenever stock drops to a threshold. Its 7-bit binary count output feeds the tens/units BCD encoders of the display path.

Parameters:
MAX_ROLHAS, 99, stock ceiling; must be ≤127.
LIMIAR_REPOSICAO, 5, refill starts when stock ≤ this value.
LOTE_REPOSICAO, 15, corks per refill batch; must be 1..15.
TIMEOUT_DISP, 20, cycles in REPONDO without dispenser supply before ESGOTADO; must be 1..31.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
en  in  1  machine running; when 0, everything except reset is frozen
sensor_vedacao  in  1  bottle-under-head sensor, level; each rising edge is one cork request
rolhas_disp  in  1  dispenser can deliver one cork this cycle
reg_r  out  7  cork stock, binary, 0..MAX_ROLHAS
req_repor  out  1  high while state is REPONDO (dispenser feed enable)
vedacao_ok  out  1  1-cycle pulse: cork consumed
falha_vedacao  out  1  1-cycle pulse: request arrived with stock 0
alarme_sem_rolhas  out  1  high while state is ESGOTADO
cheio  out  1  reg_r == MAX_ROLHAS (combinational from reg_r)
vazio  out  1  reg_r == 0 (combinational from reg_r)

Behaviour:
- Reset values: reg_r=0, state=OCIOSO, sensor_q=1 (no spurious edge if sensor is high at release), lote_cnt=0, tmo_cnt=0, all pulses 0. After reset, cheio=0, vazio=1, req_repor=0, alarme=0.
- Edge detect: borda = sensor_vedacao & ~sensor_q. sensor_q <= sensor_vedacao every cycle while en=1, and holds when en=0.
- Consumption, en=1 & borda:
  - reg_r>0: reg_r decrements and vedacao_ok=1 at the same clock edge. Latency is 1 clock from sensor sampled high.
  - reg_r=0: reg_r stays 0 and falha_vedacao=1.
- FSM states: OCIOSO, REPONDO, ESGOTADO. All transitions require en=1.
- OCIOSO -> REPONDO when reg_r ≤ LIMIAR_REPOSICAO. Evaluated on the current registered reg_r; lote_cnt and tmo_cnt clear on entry.
- In REPONDO, each cycle:
  - If rolhas_disp=1: add 1 cork, lote_cnt++, tmo_cnt clears.
  - Else: tmo_cnt++.
- REPONDO exit conditions:
  - -> OCIOSO when lote_cnt reaches LOTE_REPOSICAO on this add.
  - -> OCIOSO when the add brings reg_r to MAX_ROLHAS.
  - -> OCIOSO when reg_r==MAX_ROLHAS on entry; in that case no add occurs.
  - -> ESGOTADO when tmo_cnt reaches TIMEOUT_DISP.
- ESGOTADO -> REPONDO when rolhas_disp=1. lote_cnt and tmo_cnt clear on that transition; the first add happens on the next cycle.
- Simultaneous add and consume in the same cycle: net reg_r change is 0, vedacao_ok=1, and lote_cnt still increments.
- Add with reg_r=0 plus a request: falha_vedacao=0, vedacao_ok=1, reg_r stays 0. The arriving cork is consumed.
- reg_r never exceeds MAX_ROLHAS and never underflows. No wrap-around.
- en=0: reg_r, the state, and all counters hold; pulses are 0; req_repor and alarme reflect the held state.
- reset asserted mid-refill or in ESGOTADO: on the next edge, all registers return to their reset values.

Decomposition:
- Shared include file holds:
  - state encodings: OCIOSO=2'd0, REPONDO=2'd1, ESGOTADO=2'd2; 2'd3 is illegal and recovers to OCIOSO.
  - default constants MAX_ROLHAS, LIMIAR_REPOSICAO, LOTE_REPOSICAO, TIMEOUT_DISP, so the display and top-level blocks share them.
- One natural sub-module: modulo_detector_borda. It is a rising-edge detector with enable and with reset value 1.

Test Plan:
1. Reset, en=1, rolhas_disp=1 constant -> REPONDO one cycle after reset. reg_r counts 1..15 on consecutive cycles, then OCIOSO, req_repor=0, reg_r=15.
2. Stock 15, seal 10 sensor pulses (separated by low cycles) -> reg_r=5, ten vedacao_ok pulses. The 10th consume triggers REPONDO on the next cycle and reg_r refills to 20.
3. Stock 0, rolhas_disp=0, three sensor edges -> three falha_vedacao pulses, reg_r=0. After 20 REPONDO cycles, alarme_sem_rolhas=1. Raising rolhas_disp returns the block to REPONDO with alarme=0, then reg_r increments.
4. Stock 90 via refills, force stock ≤ threshold is impossible, so drive a long refill from stock 88 with LOTE=15 -> reg_r saturates at 99, cheio=1, and the state returns to OCIOSO after 11 adds.
5. In REPONDO with rolhas_disp=1, a sensor edge on the same cycle as an add -> reg_r unchanged that cycle, vedacao_ok=1, and the batch ends one add earlier in stock terms.
6. Drop en mid-refill for 5 cycles with rolhas_disp=1 -> reg_r, the state, and the counters hold. Sensor edges during en=0 are ignored. Refill resumes when en=1. Assert reset mid-refill -> all outputs return to their reset values the next cycle.

Source files
------------

// File: rtl/modulo_contador_rolhas_pkg.sv
// Shared definitions for the cork-stock counter and the display path:
// FSM encoding, default tuning constants and counter widths.
package modulo_contador_rolhas_pkg;

  // 2'd3 is not a valid state; the FSM steers it back to OCIOSO.
  typedef enum logic [1:0] {
    OCIOSO   = 2'd0,
    REPONDO  = 2'd1,
    ESGOTADO = 2'd2,
    ILEGAL   = 2'd3
  } estado_t;

  // Defaults shared with the tens/units display encoders.
  localparam int MAX_ROLHAS_DEF       = 99;  // stock ceiling, <= 127
  localparam int LIMIAR_REPOSICAO_DEF = 5;   // refill when stock <= this
  localparam int LOTE_REPOSICAO_DEF   = 15;  // corks per batch, 1..15
  localparam int TIMEOUT_DISP_DEF     = 20;  // starved cycles, 1..31

  localparam int W_ROLHAS = 7;
  localparam int W_LOTE   = 4;
  localparam int W_TMO    = 5;

  // True when the stock value sits at the configured ceiling.
  function automatic logic no_teto(input logic [W_ROLHAS-1:0] rolhas,
                                   input logic [W_ROLHAS-1:0] teto);
    return (rolhas == teto);
  endfunction

endpackage

// File: rtl/modulo_contador_rolhas_detector_borda.sv
// Rising-edge detector for the bottle sensor. The history register resets
// to 1 so a sensor already high when reset releases is not taken as a request.
// The history only advances while the machine is running.
module modulo_detector_borda (
  input  logic clk,
  input  logic reset,
  input  logic en_i,
  input  logic sinal_i,
  output logic borda_o
);

  logic sinal_q;

  // Sample the sensor level while enabled; hold it when frozen.
  always_ff @(posedge clk) begin
    if (reset) begin
      sinal_q <= 1'b1;
    end else if (en_i) begin
      sinal_q <= sinal_i;
    end
  end

  assign borda_o = sinal_i & ~sinal_q;

endmodule

// File: rtl/modulo_contador_rolhas.sv
// Cork-stock counter for the sealing head.
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   OCIOSO   | stock above threshold, dispenser idle
//   REPONDO  | refilling one cork per supplied cycle, req_repor high
//   ESGOTADO | dispenser starved for too long, alarm raised
//
// Consumption is independent of the state: a sensor rising edge always
// tries to take a cork, and a cork arriving in the same cycle counts.
module modulo_contador_rolhas
  import modulo_contador_rolhas_pkg::*;
#(
  parameter int MAX_ROLHAS       = MAX_ROLHAS_DEF,
  parameter int LIMIAR_REPOSICAO = LIMIAR_REPOSICAO_DEF,
  parameter int LOTE_REPOSICAO   = LOTE_REPOSICAO_DEF,
  parameter int TIMEOUT_DISP     = TIMEOUT_DISP_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic                sensor_vedacao,
  input  logic                rolhas_disp,
  output logic [W_ROLHAS-1:0] reg_r,
  output logic                req_repor,
  output logic                vedacao_ok,
  output logic                falha_vedacao,
  output logic                alarme_sem_rolhas,
  output logic                cheio,
  output logic                vazio
);

  localparam logic [W_ROLHAS-1:0] MAX_R    = W_ROLHAS'(MAX_ROLHAS);
  localparam logic [W_ROLHAS-1:0] LIMIAR_R = W_ROLHAS'(LIMIAR_REPOSICAO);
  localparam logic [W_LOTE-1:0]   LOTE_R   = W_LOTE'(LOTE_REPOSICAO);
  localparam logic [W_TMO-1:0]    TMO_R    = W_TMO'(TIMEOUT_DISP);

  estado_t               estado_q, estado_d;
  logic [W_ROLHAS-1:0]   rolhas_q, rolhas_d;
  logic [W_LOTE-1:0]     lote_q, lote_d;
  logic [W_TMO-1:0]      tmo_q, tmo_d;
  logic                  ok_q, ok_d;
  logic                  falha_q, falha_d;
  logic                  borda;
  logic                  adiciona;
  logic                  consome;

  modulo_detector_borda u_detector_borda (
    .clk     (clk),
    .reset   (reset),
    .en_i    (en),
    .sinal_i (sensor_vedacao),
    .borda_o (borda)
  );

  // Next-state, stock arithmetic and sealing pulses; nothing moves when en=0.
  always_comb begin
    estado_d = estado_q;
    rolhas_d = rolhas_q;
    lote_d   = lote_q;
    tmo_d    = tmo_q;
    ok_d     = 1'b0;
    falha_d  = 1'b0;
    adiciona = 1'b0;
    consome  = 1'b0;

    if (en) begin
      unique case (estado_q)
        OCIOSO: begin
          if (rolhas_q <= LIMIAR_R) begin
            estado_d = REPONDO;
            lote_d   = '0;
            tmo_d    = '0;
          end
        end
        REPONDO: begin
          if (no_teto(rolhas_q, MAX_R)) begin
            // Already full on entry: leave without adding.
            estado_d = OCIOSO;
          end else if (rolhas_disp) begin
            adiciona = 1'b1;
            lote_d   = lote_q + 1'b1;
            tmo_d    = '0;
          end else begin
            tmo_d = tmo_q + 1'b1;
            if (tmo_d == TMO_R) begin
              estado_d = ESGOTADO;
            end
          end
        end
        ESGOTADO: begin
          // Supply is back; the first add happens on the following cycle.
          if (rolhas_disp) begin
            estado_d = REPONDO;
            lote_d   = '0;
            tmo_d    = '0;
          end
        end
        default: begin
          estado_d = OCIOSO;
          lote_d   = '0;
          tmo_d    = '0;
        end
      endcase

      // A cork delivered this cycle can satisfy a request even at zero stock.
      if (borda) begin
        if ((rolhas_q != '0) || adiciona) begin
          consome = 1'b1;
          ok_d    = 1'b1;
        end else begin
          falha_d = 1'b1;
        end
      end

      rolhas_d = rolhas_q + {{(W_ROLHAS-1){1'b0}}, adiciona}
                          - {{(W_ROLHAS-1){1'b0}}, consome};

      // Batch complete or head full: stop the dispenser.
      if (adiciona && ((lote_d == LOTE_R) || no_teto(rolhas_d, MAX_R))) begin
        estado_d = OCIOSO;
      end
    end
  end

  // State, stock, batch/timeout counters and pulse registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      estado_q <= OCIOSO;
      rolhas_q <= '0;
      lote_q   <= '0;
      tmo_q    <= '0;
      ok_q     <= 1'b0;
      falha_q  <= 1'b0;
    end else begin
      estado_q <= estado_d;
      rolhas_q <= rolhas_d;
      lote_q   <= lote_d;
      tmo_q    <= tmo_d;
      ok_q     <= ok_d;
      falha_q  <= falha_d;
    end
  end

  assign reg_r             = rolhas_q;
  assign req_repor         = (estado_q == REPONDO);
  assign alarme_sem_rolhas = (estado_q == ESGOTADO);
  assign vedacao_ok        = ok_q;
  assign falha_vedacao     = falha_q;
  assign cheio             = no_teto(rolhas_q, MAX_R);
  assign vazio             = (rolhas_q == '0);

endmodule

// File: tb/tb_modulo_contador_rolhas.sv
// Bench for the cork-stock counter: directed scenarios plus a random soak,
// two instances (default tuning, and a high threshold that can reach the ceiling).
module tb_modulo_contador_rolhas;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, en, sensor_vedacao, rolhas_disp;

  logic [6:0] reg_a, reg_b;
  logic req_a, ok_a, falha_a, alarme_a, cheio_a, vazio_a;
  logic req_b, ok_b, falha_b, alarme_b, cheio_b, vazio_b;

  modulo_contador_rolhas u_dut_a (
    .clk(clk), .reset(reset), .en(en), .sensor_vedacao(sensor_vedacao),
    .rolhas_disp(rolhas_disp), .reg_r(reg_a), .req_repor(req_a),
    .vedacao_ok(ok_a), .falha_vedacao(falha_a),
    .alarme_sem_rolhas(alarme_a), .cheio(cheio_a), .vazio(vazio_a)
  );

  modulo_contador_rolhas #(.LIMIAR_REPOSICAO(88), .TIMEOUT_DISP(7)) u_dut_b (
    .clk(clk), .reset(reset), .en(en), .sensor_vedacao(sensor_vedacao),
    .rolhas_disp(rolhas_disp), .reg_r(reg_b), .req_repor(req_b),
    .vedacao_ok(ok_b), .falha_vedacao(falha_b),
    .alarme_sem_rolhas(alarme_b), .cheio(cheio_b), .vazio(vazio_b)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: mode 0 idle, 1 refilling, 2 starved.
  int m_max[2]  = '{99, 99};
  int m_lim[2]  = '{5, 88};
  int m_lote[2] = '{15, 15};
  int m_tmo[2]  = '{20, 7};
  int st[2], mode[2], lote[2], tmo[2];
  bit prev[2], ok[2], falha[2];

  function automatic void model_step(int i);
    int nm, add, con;
    bit req;
    if (reset) begin
      st[i] = 0; mode[i] = 0; lote[i] = 0; tmo[i] = 0;
      prev[i] = 1'b1; ok[i] = 1'b0; falha[i] = 1'b0;
      return;
    end
    ok[i] = 1'b0; falha[i] = 1'b0;
    if (!en) return;
    req = sensor_vedacao && !prev[i];
    prev[i] = sensor_vedacao;
    nm = mode[i]; add = 0; con = 0;
    if (mode[i] == 0) begin
      if (st[i] <= m_lim[i]) begin nm = 1; lote[i] = 0; tmo[i] = 0; end
    end else if (mode[i] == 1) begin
      if (st[i] == m_max[i]) nm = 0;
      else if (rolhas_disp) begin add = 1; lote[i]++; tmo[i] = 0; end
      else begin
        tmo[i]++;
        if (tmo[i] == m_tmo[i]) nm = 2;
      end
    end else if (rolhas_disp) begin
      nm = 1; lote[i] = 0; tmo[i] = 0;
    end
    if (req) begin
      if (st[i] > 0 || add == 1) begin con = 1; ok[i] = 1'b1; end
      else falha[i] = 1'b1;
    end
    st[i] = st[i] + add - con;
    if (add == 1 && (lote[i] == m_lote[i] || st[i] == m_max[i])) nm = 0;
    mode[i] = nm;
  endfunction

  task automatic tick();
    model_step(0);
    model_step(1);
    @(posedge clk);
    #1;
    chk("a_reg",    32'(reg_a),    32'(st[0]));
    chk("a_req",    32'(req_a),    32'(mode[0] == 1));
    chk("a_ok",     32'(ok_a),     32'(ok[0]));
    chk("a_falha",  32'(falha_a),  32'(falha[0]));
    chk("a_alarme", 32'(alarme_a), 32'(mode[0] == 2));
    chk("a_cheio",  32'(cheio_a),  32'(st[0] == m_max[0]));
    chk("a_vazio",  32'(vazio_a),  32'(st[0] == 0));
    chk("b_reg",    32'(reg_b),    32'(st[1]));
    chk("b_req",    32'(req_b),    32'(mode[1] == 1));
    chk("b_ok",     32'(ok_b),     32'(ok[1]));
    chk("b_falha",  32'(falha_b),  32'(falha[1]));
    chk("b_alarme", 32'(alarme_b), 32'(mode[1] == 2));
    chk("b_cheio",  32'(cheio_b),  32'(st[1] == m_max[1]));
    chk("b_vazio",  32'(vazio_b),  32'(st[1] == 0));
  endtask

  task automatic pulso();
    sensor_vedacao = 1'b1; tick();
    sensor_vedacao = 1'b0; tick();
  endtask

  initial begin
    int bias;
    reset = 1'b1; en = 1'b1; sensor_vedacao = 1'b0; rolhas_disp = 1'b1;
    tick(); tick();
    chk("rst_reg", 32'(reg_a), 0);
    chk("rst_vazio", 32'(vazio_a), 1);
    chk("rst_cheio", 32'(cheio_a), 0);
    reset = 1'b0;

    // Initial batch from empty
    repeat (17) tick();
    chk("t1_stock", 32'(reg_a), 15);
    chk("t1_req", 32'(req_a), 0);

    // Ten seals down to threshold, then refill to 20
    rolhas_disp = 1'b0;
    repeat (10) pulso();
    chk("t2_stock", 32'(reg_a), 5);
    chk("t2_req", 32'(req_a), 1);
    rolhas_disp = 1'b1;
    repeat (16) tick();
    chk("t2_refill", 32'(reg_a), 20);

    // Drain to zero, failed requests, starvation alarm, recovery
    rolhas_disp = 1'b0;
    repeat (20) pulso();
    chk("t3_zero", 32'(reg_a), 0);
    repeat (3) begin
      sensor_vedacao = 1'b1; tick();
      chk("t3_falha", 32'(falha_a), 1);
      sensor_vedacao = 1'b0; tick();
    end
    repeat (25) tick();
    chk("t3_alarme", 32'(alarme_a), 1);
    rolhas_disp = 1'b1;
    tick();
    chk("t3_alarme_off", 32'(alarme_a), 0);
    chk("t3_req", 32'(req_a), 1);
    tick();
    chk("t3_first_add", 32'(reg_a), 1);

    // High-threshold instance: refill from 88 saturates at 99
    reset = 1'b1; tick(); reset = 1'b0;
    repeat (100) tick();
    chk("t4_stock90", 32'(reg_b), 90);
    repeat (2) pulso();
    repeat (12) tick();
    chk("t4_stock99", 32'(reg_b), 99);
    chk("t4_cheio", 32'(cheio_b), 1);
    chk("t4_req", 32'(req_b), 0);

    // Add and consume in the same cycle
    reset = 1'b1; tick(); reset = 1'b0;
    repeat (5) tick();
    chk("t5_pre", 32'(reg_a), 4);
    sensor_vedacao = 1'b1; tick();
    chk("t5_same", 32'(reg_a), 4);
    chk("t5_ok", 32'(ok_a), 1);
    sensor_vedacao = 1'b0;
    repeat (16) tick();
    chk("t5_batch", 32'(reg_a), 14);

    // Freeze mid-refill, resume, then reset mid-refill
    reset = 1'b1; tick(); reset = 1'b0;
    repeat (6) tick();
    en = 1'b0;
    repeat (5) begin sensor_vedacao = ~sensor_vedacao; tick(); end
    chk("t6_hold", 32'(reg_a), 5);
    chk("t6_req", 32'(req_a), 1);
    en = 1'b1; sensor_vedacao = 1'b0;
    tick();
    chk("t6_resume", 32'(reg_a), 6);
    reset = 1'b1; tick();
    chk("t6_rst_reg", 32'(reg_a), 0);
    chk("t6_rst_req", 32'(req_a), 0);
    reset = 1'b0;

    // Random soak
    bias = 2;
    for (int n = 0; n < 3000; n++) begin
      if (n % 200 == 0) bias = $urandom_range(0, 4);
      reset          = ($urandom_range(0, 199) == 0);
      en             = ($urandom_range(0, 9) != 0);
      sensor_vedacao = ($urandom_range(0, 2) == 0);
      rolhas_disp    = ($urandom_range(0, 3) < bias);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
